// File: rtl/t5_fetch_if.sv
// Instruction-memory fetch handshake between t5_fetch (master) and memory (slave).
interface t5_fetch_if #(
  parameter int XLEN = 32
);
  logic            istb;    // fetch strobe
  logic [XLEN-3:0] iadr;    // word address, PC bits [XLEN-1:2]
  logic            iack;    // acknowledge; idat_i valid in the same cycle
  logic [31:0]     idat_i;  // instruction word

  modport master (output istb, iadr, input iack, idat_i);
  modport slave  (input istb, iadr, output iack, idat_i);
endinterface

// File: rtl/t5_fetch.sv
// Barrel-threaded fetch stage: four harts, round-robin, one fetch in flight,
// taken-branch redirects from execute, decode outputs held while sena is low.
module t5_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            sclk,
  input  logic            srst_n,
  input  logic            sena,
  t5_fetch_if.master      imem,
  output logic [XLEN-1:0] fpc,
  output logic [31:0]     idat,
  output logic            fvld,
  input  logic            bena,
  input  logic [XLEN-1:0] bpc
);
  localparam int          AW  = XLEN - 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_e;

  state_e          state_q;
  logic [AW-1:0]   pc_q [4];
  logic [AW-1:0]   pc_d [4];
  logic [1:0]      hsel_q;
  logic            kill_q;
  logic            istb_q;
  logic [AW-1:0]   iadr_q;
  logic [XLEN-1:0] fpc_q;
  logic [31:0]     idat_q;
  logic            fvld_q;
  logic [31:0]     ibuf_q;
  logic [AW-1:0]   bufpc_q;

  logic [1:0]      hsel_nx;
  logic            hit;
  logic            kill_now;
  logic            inc_en;

  assign imem.istb = istb_q;
  assign imem.iadr = iadr_q;
  assign fpc       = fpc_q;
  assign idat      = idat_q;
  assign fvld      = fvld_q;

  assign hsel_nx  = hsel_q + 2'd1;
  // A redirect to the hart whose slot is in flight or buffered squashes that slot.
  assign hit      = bena && (bpc[1:0] == hsel_q) && (state_q != BOOT);
  assign kill_now = kill_q || hit;
  // The PC advances when the word is accepted, unless the slot is being squashed.
  assign inc_en   = (state_q == REQ) && imem.iack && !kill_now;

  // Next PC per hart: redirect overrides increment; forwarded into the next iadr.
  always_comb begin
    for (int h = 0; h < 4; h++) begin
      // NOTE: default first so every path assigns pc_d and no latch is inferred.
      pc_d[h] = pc_q[h];
      if (inc_en && (hsel_q == 2'(h))) pc_d[h] = iadr_q + 1'b1;
      if (bena && (bpc[1:0] == 2'(h))) pc_d[h] = bpc[XLEN-1:2];
    end
  end

  // Fetch FSM with registered bus and decode outputs.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      // NOTE: the PC array is reset, not left to power-up, since every hart must boot at RESET_PC.
      for (int h = 0; h < 4; h++) pc_q[h] <= RESET_PC[XLEN-1:2];
      state_q <= BOOT;
      hsel_q  <= 2'd0;
      kill_q  <= 1'b0;
      istb_q  <= 1'b0;
      iadr_q  <= RESET_PC[XLEN-1:2];
      fpc_q   <= '0;
      idat_q  <= NOP;
      fvld_q  <= 1'b0;
      ibuf_q  <= NOP;
      bufpc_q <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      pc_q <= pc_d;
      case (state_q)
        BOOT: begin
          iadr_q  <= pc_d[hsel_q];
          istb_q  <= 1'b1;
          state_q <= REQ;
        end
        REQ: begin
          if (hit) kill_q <= 1'b1;
          if (imem.iack && sena) begin
            fpc_q  <= {iadr_q, hsel_q};
            idat_q <= kill_now ? NOP : imem.idat_i;
            fvld_q <= !kill_now;
            kill_q <= 1'b0;
            hsel_q <= hsel_nx;
            iadr_q <= pc_d[hsel_nx];
          end else if (imem.iack) begin
            ibuf_q  <= imem.idat_i;
            bufpc_q <= iadr_q;
            istb_q  <= 1'b0;
            state_q <= HOLD;
          end else if (sena) begin
            fpc_q  <= {iadr_q, hsel_q};
            idat_q <= NOP;
            fvld_q <= 1'b0;
          end
        end
        HOLD: begin
          if (hit) kill_q <= 1'b1;
          if (sena) begin
            fpc_q   <= {bufpc_q, hsel_q};
            idat_q  <= kill_now ? NOP : ibuf_q;
            fvld_q  <= !kill_now;
            kill_q  <= 1'b0;
            hsel_q  <= hsel_nx;
            iadr_q  <= pc_d[hsel_nx];
            istb_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_t5_fetch.sv
// Self-checking bench for t5_fetch: slot-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_t5_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        sclk = 1'b0;
  logic        srst_n;
  logic        sena, iack, bena;
  logic [31:0] bpc;
  logic [31:0] fpc, idat;
  logic        fvld;

  int checks = 0;
  int errors = 0;

  t5_fetch_if #(.XLEN(32)) imem ();

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a[13:0], 2'b11, a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign imem.iack   = iack;
  assign imem.idat_i = mem_word(imem.iadr);

  t5_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .sclk  (sclk),
    .srst_n(srst_n),
    .sena  (sena),
    .imem  (imem),
    .fpc   (fpc),
    .idat  (idat),
    .fvld  (fvld),
    .bena  (bena),
    .bpc   (bpc)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (slot level) ----------------
  logic [29:0] m_pc [4];
  logic [1:0]  m_hart;
  int          m_phase;   // 0: not yet issued, 1: request outstanding, 2: word held
  logic [29:0] m_addr;
  logic [31:0] m_word;
  logic        m_kill;
  logic [31:0] e_fpc, e_idat;
  logic        e_fvld;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pc[i] = 30'h0;
    m_hart = 2'd0; m_phase = 0; m_addr = 30'h0; m_word = NOP; m_kill = 1'b0;
    e_fpc = 32'h0; e_idat = NOP; e_fvld = 1'b0;
  endtask

  task automatic model_step();
    logic hit, killed, got, deliver;
    hit     = bena && (bpc[1:0] == m_hart) && (m_phase != 0);
    killed  = m_kill || hit;
    if (hit) m_kill = 1'b1;
    got     = (m_phase == 1) && iack;
    deliver = 1'b0;
    if (m_phase == 1) begin
      if (iack) begin
        m_word = mem_word(m_addr);
        if (sena) deliver = 1'b1; else m_phase = 2;
      end else if (sena) begin
        e_fpc = {m_addr, m_hart}; e_idat = NOP; e_fvld = 1'b0;
      end
    end else if (m_phase == 2 && sena) begin
      deliver = 1'b1;
    end
    if (got && !killed) m_pc[m_hart] = m_addr + 30'd1;
    if (bena) m_pc[bpc[1:0]] = bpc[31:2];
    if (deliver) begin
      e_fpc  = {m_addr, m_hart};
      e_idat = killed ? NOP : m_word;
      e_fvld = !killed;
      m_kill = 1'b0;
      m_hart = m_hart + 2'd1;
    end
    if (m_phase == 0 || deliver) begin
      m_addr  = m_pc[m_hart];
      m_phase = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sclk or negedge srst_n);
      if (!srst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every cycle out of reset, away from the active edge.
  initial begin
    forever begin
      @(negedge sclk);
      if (srst_n === 1'b1) begin
        check("m_istb", imem.istb, m_phase == 1);
        check("m_iadr", imem.iadr, m_addr);
        check("m_fpc",  fpc,  e_fpc);
        check("m_idat", idat, e_idat);
        check("m_fvld", fvld, e_fvld);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge sclk); #1;
  endtask

  // Reset held across edges with a redirect pending, which must be ignored.
  task automatic do_reset();
    srst_n = 1'b0; bena = 1'b1; bpc = 32'h0000_0105;
    repeat (2) @(posedge sclk);
    #1;
    bena = 1'b0; bpc = 32'h0; srst_n = 1'b1;
  endtask

  initial begin
    srst_n = 1'b0; sena = 1'b0; iack = 1'b0; bena = 1'b0; bpc = 32'h0;

    // 1: free-running round-robin
    do_reset();
    check("rst_istb", imem.istb, 1'b0);
    check("rst_iadr", imem.iadr, 30'h0);
    check("rst_fpc",  fpc,  32'h0);
    check("rst_idat", idat, NOP);
    check("rst_fvld", fvld, 1'b0);
    sena = 1'b1; iack = 1'b1;
    tick();
    check("boot_istb", imem.istb, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t1_fpc",  fpc,  32'(k));
      check("t1_fvld", fvld, 1'b1);
      check("t1_idat", idat, mem_word(30'(k >> 2)));
    end

    // 2: two wait cycles on hart 1
    do_reset(); sena = 1'b1; iack = 1'b1;
    tick(); tick();
    iack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t2_bub_fpc",  fpc,  32'h1);
      check("t2_bub_idat", idat, NOP);
      check("t2_bub_fvld", fvld, 1'b0);
      check("t2_iadr",     imem.iadr, 30'h0);
    end
    iack = 1'b1;
    tick();
    check("t2_fpc",  fpc,  32'h1);
    check("t2_fvld", fvld, 1'b1);

    // 3: sena low when hart 2 is acknowledged
    do_reset(); sena = 1'b1; iack = 1'b1;
    tick(); tick(); tick();
    sena = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t3_hold_istb", imem.istb, 1'b0);
      check("t3_hold_fpc",  fpc,  32'h1);
      check("t3_hold_fvld", fvld, 1'b1);
    end
    sena = 1'b1;
    tick();
    check("t3_fpc",  fpc,  32'h2);
    check("t3_idat", idat, mem_word(30'h0));
    check("t3_istb", imem.istb, 1'b1);
    tick();
    check("t3_next", fpc, 32'h3);

    // 4: redirect while hart 1 is waiting
    do_reset(); sena = 1'b1; iack = 1'b1;
    tick(); tick();
    iack = 1'b0; bena = 1'b1; bpc = 32'h0000_0101;
    tick();
    check("t4_bub_fpc", fpc, 32'h1);
    bena = 1'b0; bpc = 32'h0; iack = 1'b1;
    tick();
    check("t4_kill_fpc",  fpc,  32'h1);
    check("t4_kill_idat", idat, NOP);
    check("t4_kill_fvld", fvld, 1'b0);
    tick(); tick(); tick();
    check("t4_h0_fpc", fpc, 32'h4);
    check("t4_iadr",   imem.iadr, 30'h40);
    tick();
    check("t4_fpc",  fpc,  32'h101);
    check("t4_fvld", fvld, 1'b1);
    check("t4_idat", idat, mem_word(30'h40));

    // 5: PC wrap on hart 0
    do_reset(); sena = 1'b1; iack = 1'b1;
    tick(); tick();
    bena = 1'b1; bpc = 32'hFFFF_FFFC;
    tick();
    bena = 1'b0; bpc = 32'h0;
    tick(); tick();
    check("t5_iadr_max", imem.iadr, 30'h3FFF_FFFF);
    tick();
    check("t5_fpc_max", fpc, 32'hFFFF_FFFC);
    tick(); tick(); tick();
    check("t5_h3_fpc", fpc, 32'h7);
    check("t5_wrap",   imem.iadr, 30'h0);
    tick();
    check("t5_fpc0", fpc, 32'h0);

    // 6: reset pulse mid-REQ
    do_reset(); sena = 1'b1; iack = 1'b1;
    tick();
    repeat (5) tick();
    iack = 1'b0;
    tick();
    check("t6_pre_istb", imem.istb, 1'b1);
    #2;
    srst_n = 1'b0;
    #1;
    check("t6_istb", imem.istb, 1'b0);
    check("t6_iadr", imem.iadr, 30'h0);
    check("t6_fpc",  fpc,  32'h0);
    check("t6_idat", idat, NOP);
    check("t6_fvld", fvld, 1'b0);
    srst_n = 1'b1;
    tick();
    check("t6_boot_istb", imem.istb, 1'b1);
    check("t6_boot_iadr", imem.iadr, 30'h0);
    iack = 1'b1;
    tick();
    check("t6_fpc0",  fpc,  32'h0);
    check("t6_fvld0", fvld, 1'b1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
